// File: rtl/ula_pkg.sv
// Shared constants for the ULA sweep initiator:
// opcode map, sweep length and FSM state encoding.
package ula_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;
    localparam int N_OPS  = 6;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_SOMA = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/ula_varredura_if.sv
// Result stream of the sweep: one beat per opcode,
// valid/ready handshake with opcode tag and last flag.
interface ula_varredura_if #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 3
);
    logic             valid;
    logic             ready;
    logic [SEL_W-1:0] op;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (
        output valid,
        output op,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  op,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/ula_varredura.sv
// Sweeps an external ULA through every opcode for one
// latched operand pair and streams the tagged results.
module ula_varredura #(
    parameter int WIDTH = ula_pkg::DATA_W,
    parameter int SEL_W = ula_pkg::OP_W,
    parameter int N_OPS = ula_pkg::N_OPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [SEL_W-1:0] ula_seletor,
    input  logic [WIDTH-1:0] ula_resultado,
    ula_varredura_if.master  res
);
    import ula_pkg::*;

    localparam logic [SEL_W-1:0] LAST_OP = SEL_W'(N_OPS - 1);

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] op_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic             done_q;
    logic             hs;
    logic             take;

    assign take = (state == IDLE) && start;
    assign hs   = res.valid && res.ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) state_nx = APPLY;
            end
            APPLY: begin
                state_nx = OUT;
            end
            OUT: begin
                if (res.ready) begin
                    state_nx = last_q ? IDLE : APPLY;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        res.valid = 1'b0;
        unique case (1'b1)
            (state == APPLY): begin
                busy = 1'b1;
            end
            (state == OUT): begin
                busy      = 1'b1;
                res.valid = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                res.valid = 1'b0;
            end
        endcase
    end

    // Operands stay frozen for the whole sweep; start is
    // only honoured from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ula_a       <= '0;
            ula_b       <= '0;
            ula_seletor <= '0;
        end else if (take) begin
            ula_a       <= a_in;
            ula_b       <= b_in;
            ula_seletor <= SEL_W'(OP_AND);
        end else if (hs && !last_q) begin
            ula_seletor <= ula_seletor + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else if (state == APPLY) begin
            op_q   <= ula_seletor;
            data_q <= ula_resultado;
            last_q <= (ula_seletor == LAST_OP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= hs && last_q;
        end
    end

    assign res.op   = op_q;
    assign res.data = data_q;
    assign res.last = last_q;
    assign done     = done_q;

    sel_in_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        ula_seletor <= LAST_OP
    );

    stall_holds: assert property (
        @(posedge clk) disable iff (!rst_n)
        (res.valid && !res.ready) |=>
            (res.valid && $stable(res.data) &&
             $stable(res.op) && $stable(res.last))
    );

endmodule

// File: tb/tb_ula_varredura.sv
// Directed bench for ula_varredura with a behavioural ULA
// and a scoreboard of expected result beats.
module tb_ula_varredura;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] data;
        logic       last;
    } beat_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       done;
    logic [3:0] ula_a;
    logic [3:0] ula_b;
    logic [2:0] ula_seletor;
    logic [3:0] ula_res;

    ula_varredura_if #(.WIDTH(4), .SEL_W(3)) rif ();

    ula_varredura dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a_in          (a_in),
        .b_in          (b_in),
        .busy          (busy),
        .done          (done),
        .ula_a         (ula_a),
        .ula_b         (ula_b),
        .ula_seletor   (ula_seletor),
        .ula_resultado (ula_res),
        .res           (rif.master)
    );

    int         tests = 0;
    int         fails = 0;
    beat_t      sb[$];
    logic [3:0] exp_a;
    logic [3:0] exp_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ula_ref(input logic [2:0] s,
                                           input logic [3:0] a,
                                           input logic [3:0] b);
        case (s)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return ~(a & b);
            3'd4:    return a + b;
            3'd5:    return a - b;
            default: return 4'h0;
        endcase
    endfunction

    assign ula_res = ula_ref(ula_seletor, ula_a, ula_b);

    function automatic logic [23:0] ref_vec(input logic [3:0] a,
                                            input logic [3:0] b);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[4*k +: 4] = ula_ref(3'(k), a, b);
        return r;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {busy, done, ula_a, ula_b, ula_seletor, rif.valid,
                    rif.op, rif.data, rif.last}, 32'h0);
    endtask

    // Called at a negedge; start is sampled at the next posedge.
    task automatic drive_start(input logic [3:0] a,
                               input logic [3:0] b,
                               input logic [23:0] exp);
        beat_t t;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        exp_a = a;
        exp_b = b;
        for (int k = 0; k < 6; k++) begin
            t.op   = 3'(k);
            t.data = exp[4*k +: 4];
            t.last = (k == 5);
            sb.push_back(t);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs from cycle 1 (first negedge after the start edge).
    task automatic drain(input int  rnd,
                         input int  want_first,
                         input int  want_done,
                         input bit  poke,
                         input bit  abort3,
                         output bit aborted);
        beat_t held;
        beat_t got;
        bit    stalled;
        int    first;
        int    stall_run;
        bit    timed_out;
        stalled   = 1'b0;
        first     = -1;
        stall_run = 0;
        aborted   = 1'b0;
        timed_out = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc > 1) @(negedge clk);
            start = 1'b0;
            if (rnd == 0 || stall_run >= 4) rif.ready = 1'b1;
            else rif.ready = 1'($urandom_range(0, 1));
            if (cyc == 1) check("busy_cycle1", busy, 1);
            if (stalled) begin
                check("stall_valid", rif.valid, 1);
                check("stall_beat", {rif.op, rif.data, rif.last}, held);
                stalled = 1'b0;
            end
            if (rif.valid) begin
                if (first < 0) begin
                    first = cyc;
                    if (want_first > 0) check("first_beat_cycle", cyc, want_first);
                end
                if (abort3 && rif.op == 3'd3) begin
                    rif.ready = 1'b0;
                    #2 rst_n = 1'b0;
                    #1 check_zero("async_reset_zero");
                    aborted = 1'b1;
                    return;
                end
                if (poke && rif.op == 3'd2) begin
                    start = 1'b1;
                    a_in  = ~exp_a;
                    b_in  = ~exp_b;
                end
                check("ula_a_const", ula_a, exp_a);
                check("ula_b_const", ula_b, exp_b);
                check("sel_matches_op", ula_seletor, rif.op);
                if (rif.ready) begin
                    stall_run = 0;
                    if (sb.size() == 0) begin
                        check("beat_expected", sb.size(), 1);
                    end else begin
                        got = sb.pop_front();
                        check("beat_op", rif.op, got.op);
                        check("beat_data", rif.data, got.data);
                        check("beat_last", rif.last, got.last);
                    end
                end else begin
                    stall_run++;
                    stalled = 1'b1;
                    held    = {rif.op, rif.data, rif.last};
                end
            end
            if (done) begin
                check("done_busy_low", busy, 0);
                check("sb_drained", sb.size(), 0);
                if (want_done > 0) check("done_cycle", cyc, want_done);
                timed_out = 1'b0;
                break;
            end
        end
        check("sweep_timeout", timed_out, 0);
    endtask

    bit ab;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        a_in      = 4'h0;
        b_in      = 4'h0;
        rif.ready = 1'b0;
        exp_a     = 4'h0;
        exp_b     = 4'h0;
        #2 check_zero("reset_state");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle_after_reset");

        drive_start(4'b1010, 4'b0110, {4'h4, 4'h0, 4'hD, 4'h5, 4'hE, 4'h2});
        drain(0, 2, 13, 1'b0, 1'b0, ab);

        // Start in the done cycle: second sweep follows at once.
        drive_start(4'b1111, 4'b0001, {4'hE, 4'h0, 4'hE, 4'h0, 4'hF, 4'h1});
        drain(0, 2, 13, 1'b0, 1'b0, ab);

        @(negedge clk);
        check("soma_sub_ref", ref_vec(4'b0011, 4'b1101) >> 16, 8'h60);
        drive_start(4'b0011, 4'b1101, ref_vec(4'b0011, 4'b1101));
        drain(1, 2, 0, 1'b0, 1'b0, ab);

        @(negedge clk);
        drive_start(4'b0101, 4'b1001, ref_vec(4'b0101, 4'b1001));
        drain(0, 2, 13, 1'b1, 1'b0, ab);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("single_done", {done, busy}, 2'b00);
        end

        drive_start(4'b0110, 4'b0011, ref_vec(4'b0110, 4'b0011));
        drain(0, 2, 13, 1'b0, 1'b1, ab);
        check("abort_reached", ab, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {done, busy}, 2'b00);
        end

        drive_start(4'b0110, 4'b0011, ref_vec(4'b0110, 4'b0011));
        drain(0, 2, 13, 1'b0, 1'b0, ab);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
